// File: rtl/weight_update_writer_if.sv
// Handshake and RAM-port bundle for weight_update_writer.
// master: the controller/RAM side; slave: the update engine itself.
interface weight_update_writer_if;
    logic         start;
    logic         layer;
    logic [53:0]  delta_flat;
    logic [53:0]  act_flat;
    logic [255:0] mem_rdata;
    logic [3:0]   mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_we;
    logic         busy;
    logic         done;

    modport master (
        output start, layer, delta_flat, act_flat, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done
    );

    modport slave (
        input  start, layer, delta_flat, act_flat, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done
    );
endinterface

// File: rtl/weight_update_writer.sv
// weight_update_writer: read one 256-bit weight word, apply
// w_new = sat(w - ((delta*act) >>> LR_SHIFT)) to every weight of the
// selected layer (one weight per cycle), then write the word back.
// Optional build macro WU_ROUND_EN: round half up instead of truncating
// the shifted product toward -inf.
module weight_update_writer #(
    parameter int         WWIDTH   = 8,
    parameter int         LR_SHIFT = 4,
    parameter logic [3:0] L1_ADDR  = 4'd0,
    parameter logic [3:0] L2_ADDR  = 4'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    weight_update_writer_if.slave bus_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_CAPTURE, S_UPDATE, S_WRITE, S_DONE
    } state_t;

    localparam logic signed [18:0] SAT_MAX = 19'((1 << (WWIDTH - 1)) - 1);
    localparam logic signed [18:0] SAT_MIN = -SAT_MAX - 19'sd1;

    state_t            state_q, state_d;
    logic              layer_q;
    logic [3:0]        addr_q;
    logic [255:0]      word_q;
    logic [4:0]        cnt_q;
    logic [2:0]        k_q;   // delta index
    logic [2:0]        j_q;   // activation index
    logic signed [8:0] delta_q [6];
    logic signed [8:0] act_q   [6];
    logic signed [8:0] delta_in [6];
    logic signed [8:0] act_in   [6];

    logic signed [8:0]        d_sel, a_sel;
    logic signed [17:0]       prod;
    logic signed [18:0]       shifted;
    logic signed [WWIDTH-1:0] w_cur;
    logic signed [18:0]       diff;
    logic [WWIDTH-1:0]        w_new;
    logic                     last_weight;
    logic [2:0]               j_last;

    for (genvar gi = 0; gi < 6; gi++) begin : g_unpack
        assign delta_in[gi] = bus_if.delta_flat[9*gi +: 9];
        assign act_in[gi]   = bus_if.act_flat[9*gi +: 9];
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus_if.start) state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_UPDATE;
            S_UPDATE:  if (last_weight) state_d = S_WRITE;
            S_WRITE:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; write data only presented during WRITE
    always_comb begin
        bus_if.mem_addr  = addr_q;
        bus_if.mem_we    = (state_q == S_WRITE);
        bus_if.mem_wdata = (state_q == S_WRITE) ? word_q : '0;
        bus_if.busy      = (state_q == S_RD_WAIT) || (state_q == S_CAPTURE) ||
                           (state_q == S_UPDATE)  || (state_q == S_WRITE);
        bus_if.done      = (state_q == S_DONE);
    end

    // Per-weight arithmetic: product, learning-rate shift, subtract, saturate
    always_comb begin
        d_sel = delta_q[k_q];
        a_sel = act_q[j_q];
        prod  = $signed({{9{d_sel[8]}}, d_sel}) * $signed({{9{a_sel[8]}}, a_sel});
`ifdef WU_ROUND_EN
        shifted = ($signed({prod[17], prod}) + (19'sd1 <<< (LR_SHIFT - 1))) >>> LR_SHIFT;
`else
        shifted = $signed({prod[17], prod}) >>> LR_SHIFT;
`endif
        w_cur = word_q[cnt_q*WWIDTH +: WWIDTH];
        diff  = $signed({{(19-WWIDTH){w_cur[WWIDTH-1]}}, w_cur}) - shifted;
        if (diff > SAT_MAX)      w_new = SAT_MAX[WWIDTH-1:0];
        else if (diff < SAT_MIN) w_new = SAT_MIN[WWIDTH-1:0];
        else                     w_new = diff[WWIDTH-1:0];
        // Layer 1 walks 6 deltas x 4 inputs, layer 2 walks 2 deltas x 6 hidden
        j_last      = layer_q ? 3'd5 : 3'd3;
        last_weight = layer_q ? (cnt_q == 5'd11) : (cnt_q == 5'd23);
    end

    // Datapath registers: operand latch, word capture and in-place update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            layer_q <= 1'b0;
            addr_q  <= 4'd0;
            word_q  <= '0;
            cnt_q   <= 5'd0;
            k_q     <= 3'd0;
            j_q     <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                delta_q[i] <= '0;
                act_q[i]   <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus_if.start) begin
                        layer_q <= bus_if.layer;
                        addr_q  <= bus_if.layer ? L2_ADDR : L1_ADDR;
                        for (int i = 0; i < 6; i++) begin
                            delta_q[i] <= delta_in[i];
                            act_q[i]   <= act_in[i];
                        end
                    end
                end
                S_CAPTURE: begin
                    word_q <= bus_if.mem_rdata;
                    cnt_q  <= 5'd0;
                    k_q    <= 3'd0;
                    j_q    <= 3'd0;
                end
                S_UPDATE: begin
                    word_q[cnt_q*WWIDTH +: WWIDTH] <= w_new;
                    cnt_q <= cnt_q + 5'd1;
                    if (j_q == j_last) begin
                        j_q <= 3'd0;
                        k_q <= k_q + 3'd1;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_writer.sv
// Randomised scoreboard bench for weight_update_writer with a RAM model.
module tb_weight_update_writer;
    localparam int LR_SHIFT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_update_writer_if bus();

    weight_update_writer #(
        .WWIDTH(8), .LR_SHIFT(LR_SHIFT), .L1_ADDR(4'd0), .L2_ADDR(4'd1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_if(bus)
    );

    // RAM model: registered read, write on mem_we, bench preload port
    logic [255:0] ram [16];
    logic         setup_we;
    logic [3:0]   setup_addr;
    logic [255:0] setup_data;
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we)    ram[bus.mem_addr] <= bus.mem_wdata;
        else if (setup_we) ram[setup_addr]   <= setup_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   addr;
        logic [255:0] data;
        int           we_cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_due = -1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: each weight n uses delta k and act i with n = per*k + i
    function automatic logic [255:0] ref_word(input logic [255:0] w, input bit lyr,
                                              input logic [53:0] d, input logic [53:0] a);
        logic [255:0] r;
        int n_tot;
        int per;
        int den;
        r     = w;
        n_tot = lyr ? 12 : 24;
        per   = lyr ? 6 : 4;
        den   = 1 << LR_SHIFT;
        for (int n = 0; n < n_tot; n++) begin
            int k;
            int i;
            int dv;
            int av;
            int p;
            int s;
            int wv;
            int nv;
            k  = n / per;
            i  = n % per;
            dv = $signed(d[9*k +: 9]);
            av = $signed(a[9*i +: 9]);
            wv = $signed(w[8*n +: 8]);
            p  = dv * av;
`ifdef WU_ROUND_EN
            p = p + den / 2;
`endif
            s  = (p >= 0) ? p / den : -((-p + den - 1) / den);
            nv = wv - s;
            if (nv > 127)  nv = 127;
            if (nv < -128) nv = -128;
            r[8*n +: 8] = 8'(nv);
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [53:0] rand54();
        return 54'({$urandom(), $urandom()});
    endfunction

    // Monitor: every write must match the oldest expectation; done follows one cycle later
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got mem_we=1 at cycle %0d required no write", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("we_addr", 256'(bus.mem_addr), 256'(mon_e.addr));
                    chk("we_data", bus.mem_wdata, mon_e.data);
                    chk("we_edge", 256'(cyc), 256'(mon_e.we_cyc));
                    done_due = cyc + 1;
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_edge", 256'(cyc), 256'(done_due));
                done_due = -1;
            end
        end
    end

    task automatic ram_set(input logic [3:0] addr, input logic [255:0] data);
        @(negedge clk);
        setup_we   = 1'b1;
        setup_addr = addr;
        setup_data = data;
        @(negedge clk);
        setup_we   = 1'b0;
    endtask

    task automatic run_op(input bit lyr, input logic [53:0] d, input logic [53:0] a, input bit glitch);
        int   n;
        int   prev;
        int   waited;
        exp_t e;
        n = lyr ? 12 : 24;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.layer      = lyr;
        bus.delta_flat = d;
        bus.act_flat   = a;
        e.addr   = lyr ? 4'd1 : 4'd0;
        e.data   = ref_word(ram[e.addr], lyr, d, a);
        e.we_cyc = cyc + 1 + n + 2;
        exp_q.push_back(e);
        prev = done_cnt;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.layer      = ~lyr;
        bus.delta_flat = rand54();
        bus.act_flat   = rand54();
        chk("busy_high", 256'(bus.busy), 256'(1));
        if (glitch) begin
            @(negedge clk);
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        waited = 0;
        while (done_cnt == prev && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (done_cnt == prev) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles required done", waited);
        end
        repeat (4) @(negedge clk);
        chk("done_count", 256'(done_cnt), 256'(prev + 1));
        chk("busy_low", 256'(bus.busy), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w;
        logic [255:0] saved;
        logic [53:0]  d;
        logic [53:0]  a;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.layer      = 1'b0;
        bus.delta_flat = '0;
        bus.act_flat   = '0;
        setup_we       = 1'b0;
        setup_addr     = '0;
        setup_data     = '0;
        #1;
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_we", 256'(bus.mem_we), 256'(0));
        chk("rst_addr", 256'(bus.mem_addr), 256'(0));
        chk("rst_wdata", bus.mem_wdata, 256'(0));
        ram_set(4'd0, rand256());
        ram_set(4'd1, rand256());
        @(negedge clk);
        rst_n = 1'b1;

        // Layer 1: w0=10, delta0=16, act0=4 -> 6
        w = rand256(); w[7:0] = 8'd10; ram_set(4'd0, w);
        d = rand54(); a = rand54(); d[8:0] = 9'd16; a[8:0] = 9'd4;
        run_op(1'b0, d, a, 1'b0);
        chk("l1_w0_basic", 256'(ram[0][7:0]), 256'(8'd6));

        // Saturation low: -120 - 625 -> -128
        w = rand256(); w[7:0] = 8'h88; ram_set(4'd0, w);
        d = rand54(); a = rand54(); d[8:0] = 9'd100; a[8:0] = 9'd100;
        run_op(1'b0, d, a, 1'b0);
        chk("l1_sat_low", 256'(ram[0][7:0]), 256'(8'h80));

        // Saturation high: 120 + 625 -> 127
        w = rand256(); w[7:0] = 8'h78; ram_set(4'd0, w);
        d = rand54(); a = rand54(); d[8:0] = 9'h19C; a[8:0] = 9'd100;
        run_op(1'b0, d, a, 1'b0);
        chk("l1_sat_high", 256'(ram[0][7:0]), 256'(8'h7F));

        // Layer 2: delta1=-1, act5=1, w11=5; upper bits untouched
        w = rand256(); w[95:88] = 8'd5; ram_set(4'd1, w); saved = w;
        d = rand54(); a = rand54(); d[17:9] = 9'h1FF; a[53:45] = 9'd1;
        run_op(1'b1, d, a, 1'b0);
`ifdef WU_ROUND_EN
        chk("l2_w11", 256'(ram[1][95:88]), 256'(8'd5));
`else
        chk("l2_w11", 256'(ram[1][95:88]), 256'(8'd6));
`endif
        chk("l2_upper", 256'(ram[1][255:96]), 256'(saved[255:96]));

        // start pulsed while busy is ignored
        ram_set(4'd0, rand256());
        run_op(1'b0, rand54(), rand54(), 1'b1);

        // Reset at edge 10 of a layer-1 update aborts without writing
        saved = ram[0];
        @(negedge clk);
        bus.start      = 1'b1;
        bus.layer      = 1'b0;
        bus.delta_flat = rand54();
        bus.act_flat   = rand54();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 256'(bus.busy), 256'(0));
        chk("abort_we", 256'(bus.mem_we), 256'(0));
        chk("abort_addr", 256'(bus.mem_addr), 256'(0));
        chk("abort_wdata", bus.mem_wdata, 256'(0));
        chk("abort_done", 256'(bus.done), 256'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_ram", ram[0], saved);
        run_op(1'b0, rand54(), rand54(), 1'b0);

        // All-zero deltas leave the word unchanged
        saved = ram[1];
        run_op(1'b1, 54'd0, rand54(), 1'b0);
        chk("zero_l2", ram[1], saved);
        saved = ram[0];
        run_op(1'b0, 54'd0, rand54(), 1'b0);
        chk("zero_l1", ram[0], saved);

        // Random updates
        for (int t = 0; t < 10; t++) begin
            ram_set(4'd0, rand256());
            ram_set(4'd1, rand256());
            run_op(1'($urandom_range(0, 1)), rand54(), rand54(), 1'b0);
        end

        chk("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_update_writer.md
Name: weight_update_writer

Overview:
Write-back half of the backprop engine. After the forward/delta pass, this block reads one 256-bit weight word from the weight RAM and applies w_new = w - ((delta*act) >>> LR_SHIFT) to every weight of the selected layer. It then writes the word back to the same address. It drives the RAM write port (we=1) and is the writer counterpart of the forward-pass weight reader.

Parameters:
WWIDTH, 8, width of one signed weight in the RAM word
LR_SHIFT, 4, learning rate as an arithmetic right shift (eta = 2^-LR_SHIFT); legal range 1..8
L1_ADDR, 0, RAM address of layer-1 weights (24 weights)
L2_ADDR, 1, RAM address of layer-2 weights (12 weights)

Ports:
CLK  input  1  clock, all logic on posedge
RST  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
layer  input  1  0 = layer 1 (addr L1_ADDR), 1 = layer 2 (addr L2_ADDR)
delta_flat  input  54  six signed 9-bit deltas; delta k at [9k+8:9k]
act_flat  input  54  six signed 9-bit activations; act j at [9j+8:9j]
mem_rdata  input  256  RAM read data, valid one cycle after mem_addr
mem_addr  output  4  RAM address
mem_wdata  output  256  RAM write data
mem_we  output  1  RAM write enable
busy  output  1  high while an update is in progress
done  output  1  one-cycle pulse when the write-back has completed

Behaviour:
- Reset (RST=0, async): state=IDLE; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; done=0; weight counter=0.
- IDLE: on start=1, latch layer, delta_flat and act_flat. Set mem_addr to L1_ADDR or L2_ADDR, set busy=1, go to RD_WAIT. start is ignored in every other state.
- RD_WAIT (1 cycle): go to CAPTURE.
- CAPTURE: word register <= mem_rdata; counter=0; go to UPDATE.
- UPDATE: one weight per cycle, index n = counter. N = 24 for layer 1, 12 for layer 2.
  - Layer 1: n = 4*k + i; delta = delta k (k=0..5); act = act i (i=0..3, x0..x3).
  - Layer 2: n = 6*k + j; delta = delta k (k=0..1); act = act j (j=0..5, v0..v5).
  - Compute p = delta*act as signed 18-bit.
  - Compute s = p >>> LR_SHIFT (arithmetic shift; floor toward -inf).
  - Compute r = sext(w_n) - s in 19 bits.
  - Saturate r to [-128, 127] and write it into bits [8n+7:8n] of the word register.
  - When counter = N-1, go to WRITE.
- WRITE (1 cycle): mem_we=1; mem_wdata=word register; mem_addr unchanged. Go to DONE.
  - Bits above 8N are written back unchanged (bits 255:192 for layer 1, 255:96 for layer 2).
- DONE (1 cycle): done=1, busy=0, mem_we=0. Go to IDLE.
- Latency, taking the start-sampling edge as edge 0: mem_we is high for exactly one cycle starting at edge N+2; done pulses at edge N+3. Layer 1 gives done at edge 27, layer 2 at edge 15.
- mem_we is never high outside WRITE. Reset mid-operation aborts with no write; a write, if issued, is always a complete word.
- Changes on delta_flat/act_flat/layer after start do not affect the update in progress.

Optional Feature:
WU_ROUND_EN: when defined, s = (p + 2^(LR_SHIFT-1)) >>> LR_SHIFT, which is round half up. When undefined, s = p >>> LR_SHIFT, which is truncation toward -inf. Saturation and timing are identical in both builds.

Test Plan:
- Layer 1, w0=10, delta0=16, act0=4, LR_SHIFT=4: p=64, s=4 -> w0 written as 6; mem_we high at edge 26, done at edge 27.
- Layer 1, w0=-120, delta0=100, act0=100: s=625 -> w0 saturates to -128 (0x80). With w0=120 and delta0=-100: s=-625 -> w0 saturates to 127 (0x7F).
- Layer 2, delta1=-1, act5=1, w11=5: without WU_ROUND_EN s=-1 -> w11=6; with WU_ROUND_EN s=0 -> w11=5. Word bits 255:96 are returned unchanged; write goes to addr 1.
- Pulse start at edge 3 while busy: it is ignored, a single mem_we pulse is seen, and done is a single pulse.
- Drop RST low at edge 10 of a layer-1 update: all outputs return to reset values immediately, mem_we is never asserted, and RAM contents are unchanged. After release, a new start completes normally.
- All deltas 0: the written word equals the word read, and done arrives at edge N+3.
